// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation and state encodings, special constants and operand-sign helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIN
    } state_e;

    localparam logic [63:0] DIV0_QUOT     = '1;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    function automatic logic op_signed_a(input funct3_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input funct3_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input funct3_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Combinational sign handling: operand magnitudes and sign flags on the way in,
// conditional two's-complement negate of the raw result on the way out.
module muldiv_sign_prep
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    input  logic [2*DATA_WIDTH-1:0] raw,
    input  logic                    negate,
    output logic [DATA_WIDTH-1:0]   abs_a,
    output logic [DATA_WIDTH-1:0]   abs_b,
    output logic                    neg_a,
    output logic                    neg_b,
    output logic [2*DATA_WIDTH-1:0] fixed
);

    funct3_e op;

    // The most-negative value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        op    = funct3_e'(funct3);
        neg_a = op_signed_a(op) & src_a[DATA_WIDTH-1];
        neg_b = op_signed_b(op) & src_b[DATA_WIDTH-1];
        abs_a = neg_a ? -src_a : src_a;
        abs_b = neg_b ? -src_b : src_b;
        fixed = negate ? -raw : raw;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32M instructions:
// shift-add multiply, restoring divide, fixed latency of CYCLES+2 cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CYCLES     = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    state_e          state, state_next;
    funct3_e         op_q;
    logic [W-1:0]    a_q, b_q, mag_b_q, result_q;
    logic [2*W:0]    acc;
    logic [CW-1:0]   count;
    logic            prod_neg, rem_neg;

    logic [W-1:0]    abs_a, abs_b;
    logic            neg_a, neg_b;
    logic [2*W-1:0]  fix_raw, fixed;
    logic            fix_neg;
    logic [W-1:0]    final_value;

    logic [W:0]      mul_sum;
    logic [2*W:0]    mul_next;
    logic [2*W:0]    div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [2*W:0]    div_next;

    muldiv_sign_prep #(
        .DATA_WIDTH (W)
    ) u_sign (
        .funct3 (op_q),
        .src_a  (a_q),
        .src_b  (b_q),
        .raw    (fix_raw),
        .negate (fix_neg),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .fixed  (fixed)
    );

    // A flush from any busy state wins over the normal sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !flush) state_next = PREP;
            PREP: state_next = CALC;
            CALC: if (count == '0) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && (state != IDLE)) state_next = IDLE;
    end

    always_comb begin
        mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, mag_b_q} : '0);
        mul_next  = {1'b0, mul_sum, acc[W-1:1]};
        div_shift = {acc[2*W-1:0], 1'b0};
        div_ge    = div_shift[2*W:W] >= {1'b0, mag_b_q};
        div_diff  = div_shift[2*W:W] - {1'b0, mag_b_q};
        div_next  = div_ge ? {div_diff, div_shift[W-1:1], 1'b1} : div_shift;
    end

    // Divide by zero bypasses the sign fix-up, since the raw quotient/remainder would be negated.
    always_comb begin
        fix_raw     = acc[2*W-1:0];
        fix_neg     = prod_neg;
        final_value = fixed[W-1:0];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: final_value = fixed[2*W-1:W];
            OP_DIV, OP_DIVU: begin
                fix_raw     = {{W{1'b0}}, acc[W-1:0]};
                final_value = (b_q == '0) ? DIV0_QUOT[W-1:0] : fixed[W-1:0];
            end
            OP_REM, OP_REMU: begin
                fix_raw     = {{W{1'b0}}, acc[2*W-1:W]};
                fix_neg     = rem_neg;
                final_value = (b_q == '0) ? a_q : fixed[W-1:0];
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == FIN) && !flush;
    assign Result = done ? final_value : result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            mag_b_q  <= '0;
            acc      <= '0;
            count    <= '0;
            prod_neg <= 1'b0;
            rem_neg  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q <= funct3_e'(Funct3);
                        a_q  <= SrcA;
                        b_q  <= SrcB;
                    end
                end
                PREP: begin
                    acc      <= {{(W+1){1'b0}}, abs_a};
                    mag_b_q  <= abs_b;
                    prod_neg <= neg_a ^ neg_b;
                    rem_neg  <= neg_a;
                    count    <= CW'(CYCLES - 1);
                end
                CALC: begin
                    acc <= op_is_div(op_q) ? div_next : mul_next;
                    if (count != '0) count <= count - 1'b1;
                end
                FIN: begin
                    if (!flush) result_q <= final_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int CYC = 32;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB, Result;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_WIDTH(32), .CYCLES(CYC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub, uq;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * $signed(ub);   return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                uq = ua / ub; return uq[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                uq = ua % ub; return uq[31:0];
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Leaves the bench at the negedge of the first busy cycle.
    task automatic launchOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Funct3 = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or when the cycle budget runs out).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int busyCycles, output logic [31:0] res);
        bit sawDone;
        launchOp(op, a, b);
        busyCycles = 0;
        sawDone    = 1'b0;
        res        = 'x;
        for (int i = 0; i < 200 && !sawDone; i++) begin
            if (busy) busyCycles++;
            if (done) begin
                sawDone = 1'b1;
                res     = Result;
            end else begin
                @(negedge clk);
            end
        end
        if (!sawDone) busyCycles = -1;
    endtask

    task automatic runAndCheck(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] res;
        applyStimulus(op, a, b, lat, res);
        checkOutput({tag, "_result"}, res, refModel(op, a, b));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(CYC + 2));
    endtask

    initial begin
        int          lat, cycle, donePulses;
        logic [31:0] res, firstRes, ra, rb;
        logic [2:0]  rop;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = 3'd0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", Result, 32'd0);
        reset = 1'b0;

        $display("[TB] MUL 7 x -3 with latency and busy window");
        applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, lat, res);
        checkOutput("mul_neg_result", res, 32'hFFFFFFEB);
        checkOutput("mul_neg_busy_cycles", 32'(lat), 32'(CYC + 2));
        // start raised in the done cycle must be ignored
        Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
        @(negedge clk);
        checkOutput("fin_start_ignored_busy", {31'b0, busy}, 32'd0);
        checkOutput("after_done_done", {31'b0, done}, 32'd0);
        checkOutput("result_held", Result, 32'hFFFFFFEB);
        start = 1'b0;

        $display("[TB] directed high-half, divide and corner cases");
        runAndCheck("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runAndCheck("mulh_ones",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runAndCheck("mulhsu",     3'd2, 32'hFFFFFFFF, 32'd2);
        runAndCheck("div_neg",    3'd4, 32'hFFFFFFF9, 32'd2);
        runAndCheck("rem_neg",    3'd6, 32'hFFFFFFF9, 32'd2);
        runAndCheck("divu_big",   3'd5, 32'h80000000, 32'd3);
        runAndCheck("divu_zero",  3'd5, 32'd5, 32'd0);
        runAndCheck("rem_zero",   3'd6, 32'd5, 32'd0);
        runAndCheck("div_zero_neg", 3'd4, 32'hFFFFFFF9, 32'd0);
        runAndCheck("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF);
        runAndCheck("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            runAndCheck($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb);
        end

        $display("[TB] start re-pulse while busy, then flush mid-operation");
        launchOp(3'd0, 32'd1234, 32'd5678);
        cycle = 1;
        while (!done && cycle < 100) begin
            if (cycle == 5 || cycle == 20) begin
                start = 1'b1; Funct3 = 3'd4; SrcA = $urandom; SrcB = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycle++;
        end
        start = 1'b0;
        firstRes = Result;
        checkOutput("repulse_result", firstRes, refModel(3'd0, 32'd1234, 32'd5678));
        checkOutput("repulse_latency", 32'(cycle), 32'(CYC + 2));

        launchOp(3'd7, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_result", Result, firstRes);
        donePulses = 0;
        repeat (CYC + 10) begin
            @(negedge clk);
            if (done) donePulses++;
        end
        checkOutput("flush_no_done", 32'(donePulses), 32'd0);
        checkOutput("flush_result_later", Result, firstRes);

        $display("[TB] flush in the done cycle");
        launchOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (CYC + 1) @(negedge clk);
        checkOutput("fin_done_seen", {31'b0, done}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("fin_flush_done", {31'b0, done}, 32'd0);
        checkOutput("fin_flush_result", Result, firstRes);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("fin_flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("fin_flush_result_held", Result, firstRes);

        $display("[TB] asynchronous reset mid-calculation");
        launchOp(3'd0, 32'd77, 32'd88);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_reset_done", {31'b0, done}, 32'd0);
        checkOutput("async_reset_result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        runAndCheck("post_reset_mul", 3'd0, 32'd3, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
